// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - opcodes, FSM state encoding and op helpers shared by reg_exec_unit
package exec_pkg;

  localparam logic [2:0] OP_LDI = 3'd0;
  localparam logic [2:0] OP_STA = 3'd1;
  localparam logic [2:0] OP_MOV = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_RD   = 2'd2,
    S_EX   = 2'd3
  } state_t;

  function automatic logic is_write_op(input logic [2:0] op);
    return (op == OP_LDI) || (op == OP_STA);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - combinational 8-bit ALU: accumulator op register operand, with carry and zero
module exec_alu
  import exec_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              c_out,
  output logic              z_out
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = {1'b0, acc} + {1'b0, operand};
    result = acc;
    c_out  = c_in;
    case (op)
      OP_MOV: result = operand;
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        c_out  = sum[DATA_W];
      end
      OP_SUB: begin
        result = acc - operand;
        c_out  = (acc < operand);
      end
      OP_AND: begin
        result = acc & operand;
        c_out  = 1'b0;
      end
      OP_OR: begin
        result = acc | operand;
        c_out  = 1'b0;
      end
      OP_XOR: begin
        result = acc ^ operand;
        c_out  = 1'b0;
      end
      default: ;
    endcase
    z_out = (result == '0);
  end

endmodule

// File: rtl/reg_exec_unit.sv
// rtl/reg_exec_unit.sv - single-issue execute sequencer driving a 32x8 register file
module reg_exec_unit
  import exec_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 5,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [2:0]         instr_op,
  input  logic [RADDR_W-1:0] instr_reg,
  input  logic [DATA_W-1:0]  instr_imm,
  output logic [ADDR_W-1:0]  rf_address,
  output logic [DATA_W-1:0]  rf_data_in,
  output logic               rf_enable,
  input  logic [DATA_W-1:0]  rf_data_out,
  output logic [DATA_W-1:0]  acc,
  output logic               flag_c,
  output logic               flag_z,
  output logic               done
);

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              instr_ready_q, instr_ready_d;
  logic [ADDR_W-1:0] rf_address_q, rf_address_d;
  logic [DATA_W-1:0] rf_data_in_q, rf_data_in_d;
  logic              rf_enable_q, rf_enable_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              flag_c_q, flag_c_d;
  logic              flag_z_q, flag_z_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_c;
  logic              alu_z;

  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .op      (op_q),
    .acc     (acc_q),
    .operand (rf_data_out),
    .c_in    (flag_c_q),
    .result  (alu_result),
    .c_out   (alu_c),
    .z_out   (alu_z)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rf_address_d = rf_address_q;
    rf_data_in_d = rf_data_in_q;
    rf_enable_d  = 1'b0;
    acc_d        = acc_q;
    flag_c_d     = flag_c_q;
    flag_z_d     = flag_z_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready_q) begin
          op_d         = instr_op;
          rf_address_d = ADDR_W'(instr_reg);
          if (is_write_op(instr_op)) begin
            // Write data is captured at accept so it is stable across the whole WB cycle.
            rf_data_in_d = (instr_op == OP_LDI) ? instr_imm : acc_q;
            rf_enable_d  = 1'b1;
            state_d      = S_WB;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_WB: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_RD: state_d = S_EX;
      S_EX: begin
        acc_d    = alu_result;
        flag_c_d = alu_c;
        flag_z_d = alu_z;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    instr_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= OP_LDI;
      instr_ready_q <= 1'b0;
      rf_address_q  <= '0;
      rf_data_in_q  <= '0;
      rf_enable_q   <= 1'b0;
      acc_q         <= '0;
      flag_c_q      <= 1'b0;
      flag_z_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      instr_ready_q <= instr_ready_d;
      rf_address_q  <= rf_address_d;
      rf_data_in_q  <= rf_data_in_d;
      rf_enable_q   <= rf_enable_d;
      acc_q         <= acc_d;
      flag_c_q      <= flag_c_d;
      flag_z_q      <= flag_z_d;
      done_q        <= done_d;
    end
  end

  assign instr_ready = instr_ready_q;
  assign rf_address  = rf_address_q;
  assign rf_data_in  = rf_data_in_q;
  assign rf_enable   = rf_enable_q;
  assign acc         = acc_q;
  assign flag_c      = flag_c_q;
  assign flag_z      = flag_z_q;
  assign done        = done_q;

endmodule

// File: tb/tb_reg_exec_unit.sv
// tb/tb_reg_exec_unit.sv - self-checking bench for reg_exec_unit with a behavioural register file
module tb_reg_exec_unit;
  import exec_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [4:0] instr_reg;
  logic [7:0] instr_imm;
  logic [7:0] rf_address;
  logic [7:0] rf_data_in;
  logic       rf_enable;
  logic [7:0] rf_data_out;
  logic [7:0] acc;
  logic       flag_c;
  logic       flag_z;
  logic       done;

  int checks = 0;
  int errors = 0;

  reg_exec_unit #(.DATA_W(8), .RADDR_W(5), .ADDR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_reg   (instr_reg),
    .instr_imm   (instr_imm),
    .rf_address  (rf_address),
    .rf_data_in  (rf_data_in),
    .rf_enable   (rf_enable),
    .rf_data_out (rf_data_out),
    .acc         (acc),
    .flag_c      (flag_c),
    .flag_z      (flag_z),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Register file: falling-edge write, registered rising-edge read.
  logic [7:0] rf_mem [32];
  always @(negedge clk) if (rf_enable) rf_mem[rf_address[4:0]] <= rf_data_in;
  always @(posedge clk) rf_data_out <= rf_mem[rf_address[4:0]];

  // Reference model state.
  int m_acc;
  int m_c;
  int m_z;
  int m_rf [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic [2:0] op, input logic [4:0] r, input logic [7:0] imm);
    int opnd;
    opnd = m_rf[r];
    case (op)
      OP_LDI: m_rf[r] = imm;
      OP_STA: m_rf[r] = m_acc;
      OP_MOV: m_acc = opnd;
      OP_ADD: begin m_c = (m_acc + opnd > 255); m_acc = (m_acc + opnd) % 256; end
      OP_SUB: begin m_c = (m_acc < opnd); m_acc = (m_acc - opnd + 256) % 256; end
      OP_AND: begin m_c = 0; m_acc = m_acc & opnd; end
      OP_OR:  begin m_c = 0; m_acc = m_acc | opnd; end
      default: begin m_c = 0; m_acc = m_acc ^ opnd; end
    endcase
    if (op != OP_LDI && op != OP_STA) m_z = (m_acc == 0);
  endtask

  task automatic run_instr(input logic [2:0] op, input logic [4:0] r, input logic [7:0] imm,
                           input bit hold, input logic [2:0] nop, input logic [4:0] nr,
                           input logic [7:0] nimm);
    int cyc;
    int en_cnt;
    bit wr;
    int e_din;
    instr_valid = 1'b1;
    instr_op    = op;
    instr_reg   = r;
    instr_imm   = imm;
    cyc = 0;
    while (instr_ready !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ready_wait", instr_ready, 1'b1);
    wr    = (op == OP_LDI) || (op == OP_STA);
    e_din = (op == OP_LDI) ? imm : m_acc;
    model_step(op, r, imm);
    @(posedge clk); #1;
    if (hold) begin
      instr_op  = nop;
      instr_reg = nr;
      instr_imm = nimm;
    end else begin
      instr_valid = 1'b0;
    end
    cyc    = 0;
    en_cnt = 0;
    while (done !== 1'b1 && cyc < 8) begin
      if (rf_enable === 1'b1) begin
        en_cnt++;
        chk("rf_data_in", rf_data_in, e_din);
      end
      chk("ready_busy", instr_ready, 1'b0);
      chk("rf_address", rf_address, {3'b0, r});
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_latency", cyc, wr ? 1 : 2);
    chk("wen_cycles", en_cnt, wr ? 1 : 0);
    chk("ready_at_done", instr_ready, 1'b1);
    chk("acc", acc, m_acc);
    chk("flag_c", flag_c, m_c);
    chk("flag_z", flag_z, m_z);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [4:0] r;
    logic [7:0] imm;
    bit         hold;
    logic [7:0] e_acc;
    logic       e_c;
    logic       e_z;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [2:0] cop, nop;
    logic [4:0] cr, nr;
    logic [7:0] cimm, nimm;
    int j;

    rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_reg = '0; instr_imm = '0;
    m_acc = 0; m_c = 0; m_z = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;

    tbl[0]  = '{OP_LDI, 5'd2, 8'h7F, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{OP_MOV, 5'd2, 8'h00, 1'b0, 8'h7F, 1'b0, 1'b0};
    tbl[2]  = '{OP_LDI, 5'd1, 8'hF0, 1'b0, 8'h7F, 1'b0, 1'b0};
    tbl[3]  = '{OP_MOV, 5'd1, 8'h00, 1'b0, 8'hF0, 1'b0, 1'b0};
    tbl[4]  = '{OP_ADD, 5'd1, 8'h00, 1'b0, 8'hE0, 1'b1, 1'b0};
    tbl[5]  = '{OP_LDI, 5'd3, 8'hF0, 1'b0, 8'hE0, 1'b1, 1'b0};
    tbl[6]  = '{OP_MOV, 5'd1, 8'h00, 1'b0, 8'hF0, 1'b1, 1'b0};
    tbl[7]  = '{OP_SUB, 5'd3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[8]  = '{OP_SUB, 5'd1, 8'h00, 1'b0, 8'h10, 1'b1, 1'b0};
    tbl[9]  = '{OP_LDI, 5'd4, 8'h55, 1'b0, 8'h10, 1'b1, 1'b0};
    tbl[10] = '{OP_XOR, 5'd4, 8'h00, 1'b1, 8'h45, 1'b0, 1'b0};
    tbl[11] = '{OP_STA, 5'd4, 8'h00, 1'b0, 8'h45, 1'b0, 1'b0};
    tbl[12] = '{OP_MOV, 5'd4, 8'h00, 1'b0, 8'h45, 1'b0, 1'b0};
    tbl[13] = '{OP_AND, 5'd3, 8'h00, 1'b0, 8'h40, 1'b0, 1'b0};
    tbl[14] = '{OP_OR,  5'd2, 8'h00, 1'b0, 8'h7F, 1'b0, 1'b0};
    tbl[15] = '{OP_XOR, 5'd2, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", instr_ready, 1'b0);
    chk("rst_outputs", {rf_address, rf_data_in, acc, rf_enable, flag_c, flag_z, done}, '0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready_pre_edge", instr_ready, 1'b0);
    @(posedge clk); #1;
    chk("rel_ready", instr_ready, 1'b1);

    for (int i = 0; i < 16; i++) begin
      j = (i < 15) ? i + 1 : i;
      run_instr(tbl[i].op, tbl[i].r, tbl[i].imm, tbl[i].hold, tbl[j].op, tbl[j].r, tbl[j].imm);
      chk($sformatf("tbl%0d_acc", i), acc, tbl[i].e_acc);
      chk($sformatf("tbl%0d_c", i), flag_c, tbl[i].e_c);
      chk($sformatf("tbl%0d_z", i), flag_z, tbl[i].e_z);
    end
    chk("rf_r4_sta", rf_mem[4], 8'h45);

    for (int i = 0; i < 32; i++)
      run_instr(OP_LDI, 5'(i), 8'($urandom), 1'b0, OP_LDI, 5'd0, 8'd0);
    run_instr(OP_LDI, 5'd5, 8'h33, 1'b0, OP_LDI, 5'd0, 8'd0);

    // Reset lands in WB before the falling-edge write.
    instr_valid = 1'b1; instr_op = OP_LDI; instr_reg = 5'd5; instr_imm = 8'hAA;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("wb_enable", rf_enable, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_enable", rf_enable, 1'b0);
    chk("rst_mid_outputs", {rf_address, rf_data_in, acc, flag_c, flag_z, done, instr_ready}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_acc = 0; m_c = 0; m_z = 0;
    for (int k = 0; k < 4; k++) begin
      chk("rst_no_done", done, 1'b0);
      @(posedge clk); #1;
    end
    chk("rst_no_write", rf_mem[5], 8'h33);
    run_instr(OP_MOV, 5'd5, 8'h00, 1'b0, OP_LDI, 5'd0, 8'd0);

    cop = 3'($urandom); cr = 5'($urandom); cimm = 8'($urandom);
    for (int i = 0; i < 150; i++) begin
      nop = 3'($urandom); nr = 5'($urandom); nimm = 8'($urandom);
      run_instr(cop, cr, cimm, 1'($urandom), nop, nr, nimm);
      cop = nop; cr = nr; cimm = nimm;
    end
    instr_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 32; i++)
      chk($sformatf("final_rf%0d", i), rf_mem[i], m_rf[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
